pipe_hazard_unit: RTL and testbench
===================================

# pipe_hazard_unit

Parametrised hazard, forwarding and flush controller for the in-order RISC-V pipeline. It tracks every in-flight register write in a shift-register scoreboard that spans execute through writeback, and selects forwarding sources for the decode operands. It stalls fetch/decode on unresolved dependencies, squashes the decode slot on a taken branch or jump, and keeps saturating stall/flush performance counters. It sits beside decode, between the control decoder/register file and the execute operand muxes.

## Interface
- `XLEN`, 32: counter width.
- `REG_AW`, 5: register address width.
- `DEPTH`, 3: in-flight stages tracked (entry 0 = E, 1 = M, …, DEPTH-1 = WB); ≥2.
- `FWD_EN`, 1: 1 = forwarding mode; 0 = stall-only mode.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `dec_valid` in 1: decode slot holds a real instruction.
- `dec_rs1`, `dec_rs2` in REG_AW: source addresses.
- `dec_rs1_used`, `dec_rs2_used` in 1: source actually read.
- `dec_rd` in REG_AW: destination address.
- `dec_we` in 1: instruction writes rd.
- `dec_is_load` in 1: result only available from M onward.
- `redirect` in 1: taken branch/jump resolved in E this cycle.
- `stall` out 1: hold PC and the F/D register.
- `bubble_e` out 1: inject NOP into E next edge.
- `flush_d` out 1: clear the F/D register next edge.
- `fwd_rs1_sel`, `fwd_rs2_sel` out clog2(DEPTH+1): 0 = register file, k = result of scoreboard entry k-1.
- `stall_cnt`, `flush_cnt` out XLEN: saturating event counters.

## Operation
- Scoreboard entry: {valid, rd, we, is_load}. Each edge, entry k moves to k+1 and entry DEPTH-1 retires.
- Entry 0 loads the decode instruction when `dec_valid & !stall & !redirect`; otherwise entry 0 loads invalid (bubble).
- Match on source s: entry valid & we & rd == s & s != 0 & s_used. x0 never matches.
- FWD_EN=1:
  - The youngest matching entry (lowest k) wins: sel = k+1.
  - If that entry is k=0 with is_load=1, assert `stall` and drive sel = 0.
- FWD_EN=0: any match on any entry asserts `stall`; sel is always 0.
- `bubble_e` = stall | redirect. `flush_d` = redirect.
- Redirect overrides stall: the decode instruction is squashed, so `stall`=0 while `redirect`=1.
- `stall_cnt` increments on each cycle with `stall`=1. `flush_cnt` increments on each cycle with `redirect`=1. Both hold at all-ones.

## Timing
- `stall`, `bubble_e`, `flush_d` and the select outputs are combinational from the current decode inputs and registered scoreboard state, valid in the same cycle.
- The scoreboard and counters update on the rising edge.
- Load-use in forwarding mode costs exactly 1 stall cycle. The dependent then forwards from entry 1 (sel = 2).
- Stall-only mode: a dependency on entry k stalls DEPTH-k cycles.
- Reset: all entries invalid and counters 0, so `stall`=0, `bubble_e`=`redirect`, `flush_d`=`redirect`, sels = 0. Reset during a stall clears the scoreboard, and the stall drops the next cycle.
- Redirect and load-use in the same cycle: `stall`=0, `bubble_e`=1, `flush_d`=1, and entry 0 is invalid next cycle.

## Structure
- `hazard_pkg` holds:
  - the scoreboard entry struct;
  - the `FWD_RF` = 0 select constant;
  - the select-width function clog2(DEPTH+1).
- One sub-module, `sat_counter` (width parameter, inc, reset), instantiated twice.
- Match/priority logic is a generate loop over DEPTH inside the top.

## Test plan
- DEPTH=3, FWD_EN=1: `add x5` then dependent `add x6,x5,x1` next cycle → no stall, `fwd_rs1_sel`=1; one cycle later with the same source → sel=2.
- Load x5 then dependent use of rs2=x5 → `stall`=1 and `bubble_e`=1 for 1 cycle, then `fwd_rs2_sel`=2 with `stall`=0; `stall_cnt`=1.
- Write to x0 followed by a read of x0 → never stalls, sel=0.
- FWD_EN=0: `add x5` then a read of x5 → `stall` high for 3 cycles, then sel=0; `stall_cnt`=3.
- `redirect` asserted in the same cycle as a load-use → `stall`=0, `bubble_e`=1, `flush_d`=1, `flush_cnt`=1; next cycle entry 0 is invalid.
- Force `stall` high continuously with XLEN=4 → `stall_cnt` reaches 15 and holds; `reset` mid-run → counters 0 and `stall`=0 the cycle after.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
package hazard_pkg;

  // Widest register address the scoreboard can hold; REG_AW must not exceed it.
  localparam int RD_MAX_W = 8;

  // Forwarding select value meaning "take the operand from the register file".
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                we;
    logic                is_load;
  } sb_entry_t;

  function automatic int sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard, forwarding and flush control for the in-order pipeline: a shift-register
// scoreboard of in-flight writes (E..WB) drives stall, bubble, flush and operand selects.
module pipe_hazard_unit
  import hazard_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int FWD_EN = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          dec_valid,
  input  logic [REG_AW-1:0]             dec_rs1,
  input  logic [REG_AW-1:0]             dec_rs2,
  input  logic                          dec_rs1_used,
  input  logic                          dec_rs2_used,
  input  logic [REG_AW-1:0]             dec_rd,
  input  logic                          dec_we,
  input  logic                          dec_is_load,
  input  logic                          redirect,
  output logic                          stall,
  output logic                          bubble_e,
  output logic                          flush_d,
  output logic [sel_width(DEPTH)-1:0]   fwd_rs1_sel,
  output logic [sel_width(DEPTH)-1:0]   fwd_rs2_sel,
  output logic [XLEN-1:0]               stall_cnt,
  output logic [XLEN-1:0]               flush_cnt
);

  localparam int SEL_W = sel_width(DEPTH);

  sb_entry_t           sb_q [DEPTH];
  sb_entry_t           ent0_d;
  logic [DEPTH-1:0]    hit1;
  logic [DEPTH-1:0]    hit2;
  logic [RD_MAX_W-1:0] rs1_x;
  logic [RD_MAX_W-1:0] rs2_x;
  logic [SEL_W-1:0]    sel1_raw;
  logic [SEL_W-1:0]    sel2_raw;
  logic                lu1;
  logic                lu2;
  logic                stall_raw;

  assign rs1_x = RD_MAX_W'(dec_rs1);
  assign rs2_x = RD_MAX_W'(dec_rs2);

  // x0 is hard-wired to zero, so a source of x0 never depends on anything.
  for (genvar k = 0; k < DEPTH; k++) begin : g_match
    assign hit1[k] = sb_q[k].valid & sb_q[k].we & (sb_q[k].rd == rs1_x) &
                     (dec_rs1 != '0) & dec_rs1_used;
    assign hit2[k] = sb_q[k].valid & sb_q[k].we & (sb_q[k].rd == rs2_x) &
                     (dec_rs2 != '0) & dec_rs2_used;
  end

  // Scan oldest to youngest so the youngest matching entry ends up selected.
  always_comb begin
    sel1_raw = SEL_W'(FWD_RF);
    sel2_raw = SEL_W'(FWD_RF);
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (hit1[i]) sel1_raw = SEL_W'(i + 1);
      if (hit2[i]) sel2_raw = SEL_W'(i + 1);
    end
  end

  // A load still in E has no result yet; only that case cannot be forwarded.
  assign lu1 = hit1[0] & sb_q[0].is_load;
  assign lu2 = hit2[0] & sb_q[0].is_load;

  if (FWD_EN != 0) begin : g_fwd
    assign stall_raw   = lu1 | lu2;
    assign fwd_rs1_sel = lu1 ? SEL_W'(FWD_RF) : sel1_raw;
    assign fwd_rs2_sel = lu2 ? SEL_W'(FWD_RF) : sel2_raw;
  end else begin : g_stall_only
    assign stall_raw   = (|hit1) | (|hit2);
    assign fwd_rs1_sel = SEL_W'(FWD_RF);
    assign fwd_rs2_sel = SEL_W'(FWD_RF);
  end

  // A redirect squashes the decode instruction, so its hazards no longer matter.
  assign stall    = stall_raw & ~redirect;
  assign bubble_e = stall_raw | redirect;
  assign flush_d  = redirect;

  // dec_valid qualifies the decode slot; the slot is consumed into E on an edge
  // where stall and redirect are both low, otherwise E receives a bubble.
  always_comb begin
    ent0_d = '0;
    if (dec_valid && !stall && !redirect) begin
      ent0_d.valid   = 1'b1;
      ent0_d.rd      = RD_MAX_W'(dec_rd);
      ent0_d.we      = dec_we;
      ent0_d.is_load = dec_is_load;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) sb_q[i] <= '0;
    end else begin
      sb_q[0] <= ent0_d;
      for (int i = 1; i < DEPTH; i++) sb_q[i] <= sb_q[i-1];
    end
  end

  sat_counter #(.W(XLEN)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (stall),
    .count (stall_cnt)
  );

  sat_counter #(.W(XLEN)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (redirect),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed scoreboard bench: a forwarding instance and a stall-only instance share
// stimulus; each step queues the expected outputs of the instance under test.
module tb_pipe_hazard_unit;

  logic       clock;
  logic       reset;
  logic       dec_valid;
  logic [4:0] dec_rs1;
  logic [4:0] dec_rs2;
  logic       dec_rs1_used;
  logic       dec_rs2_used;
  logic [4:0] dec_rd;
  logic       dec_we;
  logic       dec_is_load;
  logic       redirect;

  logic       f_stall, f_bub, f_flush;
  logic [1:0] f_s1, f_s2;
  logic [3:0] f_sc, f_fc;
  logic       s_stall, s_bub, s_flush;
  logic [1:0] s_s1, s_s2;
  logic [3:0] s_sc, s_fc;

  logic [23:0] exp_q[$];
  logic [23:0] e;
  logic [14:0] act;
  int          checks;
  int          errors;
  int          sc;

  pipe_hazard_unit #(.XLEN(4), .REG_AW(5), .DEPTH(3), .FWD_EN(1)) u_fwd (
    .clock(clock), .reset(reset), .dec_valid(dec_valid),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
    .dec_rd(dec_rd), .dec_we(dec_we), .dec_is_load(dec_is_load),
    .redirect(redirect), .stall(f_stall), .bubble_e(f_bub), .flush_d(f_flush),
    .fwd_rs1_sel(f_s1), .fwd_rs2_sel(f_s2), .stall_cnt(f_sc), .flush_cnt(f_fc)
  );

  pipe_hazard_unit #(.XLEN(4), .REG_AW(5), .DEPTH(3), .FWD_EN(0)) u_stl (
    .clock(clock), .reset(reset), .dec_valid(dec_valid),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
    .dec_rd(dec_rd), .dec_we(dec_we), .dec_is_load(dec_is_load),
    .redirect(redirect), .stall(s_stall), .bubble_e(s_bub), .flush_d(s_flush),
    .fwd_rs1_sel(s_s1), .fwd_rs2_sel(s_s2), .stall_cnt(s_sc), .flush_cnt(s_fc)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step(input logic [7:0] tag, input logic d, input logic rst,
                      input logic v, input logic [4:0] r1, input logic u1,
                      input logic [4:0] r2, input logic u2,
                      input logic [4:0] rd, input logic we, input logic ld,
                      input logic rdr,
                      input logic e_st, input logic e_bub, input logic e_fl,
                      input logic [1:0] e_s1, input logic [1:0] e_s2,
                      input logic [3:0] e_sc, input logic [3:0] e_fc);
    @(posedge clock);
    #1;
    reset        = rst;
    dec_valid    = v;
    dec_rs1      = r1;
    dec_rs1_used = u1;
    dec_rs2      = r2;
    dec_rs2_used = u2;
    dec_rd       = rd;
    dec_we       = we;
    dec_is_load  = ld;
    redirect     = rdr;
    exp_q.push_back({tag, d, e_st, e_bub, e_fl, e_s1, e_s2, e_sc, e_fc});
  endtask

  task automatic idle_cycle(input logic rst);
    @(posedge clock);
    #1;
    reset        = rst;
    dec_valid    = 1'b0;
    dec_rs1      = '0;
    dec_rs1_used = 1'b0;
    dec_rs2      = '0;
    dec_rs2_used = 1'b0;
    dec_rd       = '0;
    dec_we       = 1'b0;
    dec_is_load  = 1'b0;
    redirect     = 1'b0;
  endtask

  // scoreboard monitor: outputs sampled on the falling edge
  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (e[15])
        act = {s_stall, s_bub, s_flush, s_s1, s_s2, s_sc, s_fc};
      else
        act = {f_stall, f_bub, f_flush, f_s1, f_s2, f_sc, f_fc};
      checks++;
      if (act !== e[14:0]) begin
        errors++;
        $display("FAIL step %0d dut %0d got st/bub/fl/s1/s2/sc/fc=%b/%b/%b/%0d/%0d/%0d/%0d exp %b/%b/%b/%0d/%0d/%0d/%0d",
                 e[23:16], e[15], act[14], act[13], act[12], act[11:10], act[9:8], act[7:4], act[3:0],
                 e[14], e[13], e[12], e[11:10], e[9:8], e[7:4], e[3:0]);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1; dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0;
    dec_rs1_used = 1'b0; dec_rs2_used = 1'b0; dec_rd = '0;
    dec_we = 1'b0; dec_is_load = 1'b0; redirect = 1'b0;
    repeat (2) @(posedge clock);

    // forwarding instance:  tag d rst  v r1 u1 r2 u2  rd we ld rdr  st bub fl s1 s2 sc fc
    step( 0, 0, 1,  0,  0, 0,  0, 0,   0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    step( 1, 0, 1,  0,  0, 0,  0, 0,   0, 0, 0, 1,   0, 1, 1, 0, 0, 0, 0);
    step( 2, 0, 0,  1,  1, 1,  2, 1,   5, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    step( 3, 0, 0,  1,  5, 1,  1, 1,   6, 1, 0, 0,   0, 0, 0, 1, 0, 0, 0);
    step( 4, 0, 0,  1,  5, 1,  0, 1,   7, 1, 0, 0,   0, 0, 0, 2, 0, 0, 0);
    step( 5, 0, 0,  1,  1, 1,  0, 0,   5, 1, 1, 0,   0, 0, 0, 0, 0, 0, 0);
    step( 6, 0, 0,  1,  3, 1,  5, 1,   8, 1, 0, 0,   1, 1, 0, 0, 0, 0, 0);
    step( 7, 0, 0,  1,  3, 1,  5, 1,   8, 1, 0, 0,   0, 0, 0, 0, 2, 1, 0);
    step( 8, 0, 0,  1,  0, 0,  0, 0,   0, 1, 0, 0,   0, 0, 0, 0, 0, 1, 0);
    step( 9, 0, 0,  1,  0, 1,  0, 1,   0, 1, 1, 0,   0, 0, 0, 0, 0, 1, 0);
    step(10, 0, 0,  1,  0, 1,  0, 1,  11, 1, 0, 0,   0, 0, 0, 0, 0, 1, 0);
    step(11, 0, 0,  1,  0, 0,  0, 0,  10, 1, 1, 0,   0, 0, 0, 0, 0, 1, 0);
    step(12, 0, 0,  1, 10, 1,  0, 0,  12, 1, 0, 1,   0, 1, 1, 0, 0, 1, 0);
    step(13, 0, 0,  1, 12, 1, 10, 1,  13, 1, 0, 0,   0, 0, 0, 0, 2, 1, 1);
    step(14, 0, 0,  1, 10, 1, 13, 1,  14, 1, 0, 0,   0, 0, 0, 3, 1, 1, 1);
    step(15, 0, 0,  1,  0, 0,  0, 0,  13, 1, 0, 0,   0, 0, 0, 0, 0, 1, 1);
    step(16, 0, 0,  1, 13, 1, 14, 1,   0, 0, 0, 0,   0, 0, 0, 1, 2, 1, 1);

    // stall-only instance, starting from a clean reset
    idle_cycle(1'b1);
    step(20, 1, 1,  0,  0, 0,  0, 0,   0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    step(21, 1, 0,  1,  0, 0,  0, 0,   5, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    step(22, 1, 0,  1,  5, 1,  0, 0,   6, 1, 0, 0,   1, 1, 0, 0, 0, 0, 0);
    step(23, 1, 0,  1,  5, 1,  0, 0,   6, 1, 0, 0,   1, 1, 0, 0, 0, 1, 0);
    step(24, 1, 0,  1,  5, 1,  0, 0,   6, 1, 0, 0,   1, 1, 0, 0, 0, 2, 0);
    step(25, 1, 0,  1,  5, 1,  0, 0,   6, 1, 0, 0,   0, 0, 0, 0, 0, 3, 0);
    step(26, 1, 0,  0,  0, 0,  0, 0,   0, 0, 0, 0,   0, 0, 0, 0, 0, 3, 0);
    step(27, 1, 0,  1,  0, 0,  6, 1,   0, 0, 0, 0,   1, 1, 0, 0, 0, 3, 0);
    step(28, 1, 0,  1,  0, 0,  6, 1,   0, 0, 0, 0,   1, 1, 0, 0, 0, 4, 0);
    step(29, 1, 0,  1,  0, 0,  6, 1,   0, 0, 0, 0,   0, 0, 0, 0, 0, 5, 0);

    // self-dependent chain: issue, then three stall cycles, repeated until saturation
    sc = 5;
    for (int i = 0; i < 26; i++) begin
      logic st;
      st = (i % 4) != 0;
      step(8'(30 + i), 1, 0, 1, 9, 1, 0, 0, 9, 1, 0, 0,
           st, st, 0, 0, 0, 4'(sc), 0);
      if (st) sc = (sc == 15) ? 15 : sc + 1;
    end

    // reset in the middle of a stall
    step(60, 1, 1,  1,  9, 1,  0, 0,   9, 1, 0, 0,   1, 1, 0, 0, 0, 15, 0);
    step(61, 1, 0,  1,  9, 1,  0, 0,   9, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    step(62, 1, 0,  1,  9, 1,  0, 0,   9, 1, 0, 0,   1, 1, 0, 0, 0, 0, 0);

    idle_cycle(1'b0);
    for (int n = 0; n < 4 && exp_q.size() != 0; n++) @(negedge clock);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries never compared, required 0", exp_q.size());
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
